// File: rtl/dec_pkg.sv
// dec_pkg: shared state encoding and mode constants for the dec_scan_n decoder.
package dec_pkg;
   typedef enum logic [1:0] {ST_DIRECT, ST_SCAN, ST_PAUSE} state_e;
   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;
endpackage

// File: rtl/dec_onehot.sv
// dec_onehot: combinational N-to-2**N one-hot decoder with enable.
module dec_onehot #(
   parameter int N = 3
) (
   input  logic           en_i,
   input  logic [N-1:0]   a_i,
   output logic [0:2**N-1] y_o
);
   always_comb
      for (int i = 0; i < 2**N; i++) y_o[i] = en_i && (a_i == N'(i));
endmodule

// File: rtl/dec_scan_n.sv
// dec_scan_n: registered one-hot decoder with direct and scanning address modes.
// Defining DEC_SCAN_DWELL_EN adds the dwell port and per-step hold counter.
module dec_scan_n
   import dec_pkg::*;
#(
   parameter int N       = 3,
   parameter int DWELL_W = 4
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               en,
   input  logic               mode,
   input  logic [N-1:0]       w,
   input  logic               load,
`ifdef DEC_SCAN_DWELL_EN
   input  logic [DWELL_W-1:0] dwell,
`endif
   output logic [0:2**N-1]    y,
   output logic [N-1:0]       addr,
   output logic               wrap
);
   state_e             state_q, state_d;
   logic [N-1:0]       addr_q, addr_d, dec_a;
   logic [0:2**N-1]    y_q, y_d;
   logic               wrap_q, wrap_d, dec_en, step;

`ifdef DEC_SCAN_DWELL_EN
   logic [DWELL_W-1:0] cnt_q, cnt_d, dw_q, dw_eff;
   // dwell is captured on the first cycle of each step, so changes land on the next step
   assign dw_eff = (cnt_q == '0) ? dwell : dw_q;
   assign step   = cnt_q == dw_eff;
   always_comb begin
      cnt_d = cnt_q;
      if (load || state_d == ST_DIRECT) cnt_d = '0;
      else if (state_d == ST_SCAN) cnt_d = step ? '0 : cnt_q + 1'b1;
   end
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         cnt_q <= '0;
         dw_q  <= '0;
      end else begin
         cnt_q <= cnt_d;
         dw_q  <= dw_eff;
      end
`else
   // no hold counter: every scanning cycle is a step
   assign step = DWELL_W > 0;
`endif

   always_comb begin
      state_d = (mode == MODE_SCAN) ? (en ? ST_SCAN : ST_PAUSE) : ST_DIRECT;
      dec_a   = (state_d == ST_DIRECT) ? w : addr_q;
      dec_en  = (state_d == ST_DIRECT) ? en : (state_d == ST_SCAN);
      addr_d  = addr_q;
      wrap_d  = 1'b0;
      if (load) addr_d = w;
      else if (state_d == ST_SCAN && step) begin
         addr_d = addr_q + 1'b1;
         wrap_d = &addr_q;
      end
   end

   dec_onehot #(.N(N)) u_dec (
      .en_i (dec_en),
      .a_i  (dec_a),
      .y_o  (y_d)
   );

   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         state_q <= ST_DIRECT;
         addr_q  <= '0;
         y_q     <= '0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         y_q     <= y_d;
         wrap_q  <= wrap_d;
      end

   assign y    = y_q;
   assign addr = addr_q;
   assign wrap = wrap_q && state_q == ST_SCAN;
endmodule
